mem_access_unit: RTL and testbench

Initiator side of the byte-addressable data RAM port. It accepts one CPU load/store request at a time over a valid/ready handshake. It drives the RAM's byte-write-enable, address and write-data lines, then samples the combinational read data. It returns a sign- or zero-extended result and an error flag over a second valid/ready handshake. It sits between the execute stage and the data RAM.

---
 rtl/mem_access_unit_pkg.sv | 48 ++++
 rtl/mem_access_unit_load_formatter.sv | 23 ++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-RAM load/store access unit.
// Funct3 size codes, FSM states and size/byte-enable lookup live here.
package mem_access_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_e;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  // A size of zero marks an unsupported funct3 code.
  function automatic logic [2:0] op_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      OP_B, OP_BU: size = SIZE_B;
      OP_H, OP_HU: size = SIZE_H;
      OP_W:        size = SIZE_W;
      default:     size = 3'd0;
    endcase
    return size;
  endfunction

  function automatic logic [3:0] op_byte_en(input logic [2:0] funct3);
    logic [3:0] be;
    case (funct3)
      OP_B, OP_BU: be = 4'b0001;
      OP_H, OP_HU: be = 4'b0011;
      OP_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: picks the low byte/halfword/word of the
// RAM read word and sign- or zero-extends it to 32 bits.
module mem_access_unit_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  word_t      r_data,
  output word_t      ext_data
);

  always_comb begin
    ext_data = '0;
    case (funct3)
      OP_B:    ext_data = {{24{r_data[7]}}, r_data[7:0]};
      OP_BU:   ext_data = {24'd0, r_data[7:0]};
      OP_H:    ext_data = {{16{r_data[15]}}, r_data[15:0]};
      OP_HU:   ext_data = {16'd0, r_data[15:0]};
      OP_W:    ext_data = r_data;
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the byte-addressable data RAM port: one load/store at a
// time, IDLE -> ACCESS (single RAM cycle) -> RESP, with legality checking.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  ram_w_en,
  output logic [15:0] ram_addr,
  output logic [31:0] ram_w_data,
  input  logic [31:0] ram_r_data
);

  mau_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] addr_q, addr_d;
  word_t       wdata_q, wdata_d;
  logic        err_q, err_d;
  word_t       rdata_q, rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [2:0]  req_size;
  logic [16:0] req_end_addr;
  logic        req_misaligned;
  logic        req_err;
  logic        in_access;
  word_t       fmt_data;

  // Legality of the incoming request; the 17-bit end address catches any
  // access that would wrap past 0xFFFF.
  always_comb begin
    req_size       = op_size(req_funct3);
    req_end_addr   = {1'b0, req_addr[15:0]} + 17'(req_size) - 17'd1;
    req_misaligned = ((req_size == SIZE_H) && req_addr[0]) ||
                     ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
    req_err        = (req_size == 3'd0) ||
                     (req_we && ((req_funct3 == OP_BU) || (req_funct3 == OP_HU))) ||
                     (req_addr[31:16] != 16'd0) ||
                     req_end_addr[16] ||
                     (!ALLOW_MISALIGNED && req_misaligned);
  end

  mem_access_unit_load_formatter u_load_formatter (
    .funct3   (funct3_q),
    .r_data   (ram_r_data),
    .ext_data (fmt_data)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[15:0];
          wdata_d  = req_wdata;
          err_d    = req_err;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d   = (we_q || err_q) ? '0 : fmt_data;
        rsp_err_d = err_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= 16'd0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // The RAM bus is driven only during ACCESS so it idles at zero otherwise.
  always_comb begin
    in_access  = (state_q == ST_ACCESS);
    req_ready  = (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_RESP);
    rsp_rdata  = rdata_q;
    rsp_err    = rsp_err_q;
    ram_addr   = in_access ? addr_q : 16'd0;
    ram_w_data = in_access ? wdata_q : '0;
    ram_w_en   = (in_access && we_q && !err_q) ? op_byte_en(funct3_q) : 4'b0000;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte RAM model;
// a second instance with ALLOW_MISALIGNED=0 runs in lockstep.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  ram_w_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_w_data, ram_r_data;

  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_rdata_s;
  logic [3:0]  ram_w_en_s;
  logic [15:0] ram_addr_s;
  logic [31:0] ram_w_data_s;
  logic [31:0] ram_r_data_s;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  wen_seen, wen_seen_s;
  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_w_en(ram_w_en), .ram_addr(ram_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) u_dut_strict (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_s), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s),
    .rsp_err(rsp_err_s), .ram_w_en(ram_w_en_s), .ram_addr(ram_addr_s),
    .ram_w_data(ram_w_data_s), .ram_r_data(ram_r_data_s)
  );

  // Byte RAM: combinational little-endian read, byte-enabled write on the edge.
  assign ram_r_data = {mem[ram_addr + 16'd3], mem[ram_addr + 16'd2],
                       mem[ram_addr + 16'd1], mem[ram_addr]};
  assign ram_r_data_s = 32'd0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_w_en[i]) mem[ram_addr + 16'(i)] <= ram_w_data[8*i +: 8];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request from IDLE, check latency, response and byte-enable
  // pulse, optionally stall the response, then complete it.
  task automatic apply_stimulus(input string tag, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [3:0] exp_wen, input int hold);
    int lat;
    check_output({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wen_seen = ram_w_en;
    wen_seen_s = ram_w_en_s;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      wen_seen |= ram_w_en;
      wen_seen_s |= ram_w_en_s;
      lat++;
    end
    check_output({tag, "/latency"}, 32'(lat), 32'd2);
    check_output({tag, "/rdata"}, rsp_rdata, exp_rdata);
    check_output({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    check_output({tag, "/w_en"}, 32'(wen_seen), 32'(exp_wen));
    for (int k = 0; k < hold; k++) begin
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; req_valid = 1'b1;
      @(negedge clk);
      check_output({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      check_output({tag, "/hold_rdata"}, rsp_rdata, exp_rdata);
      check_output({tag, "/hold_err"}, 32'(rsp_err), 32'(exp_err));
      check_output({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_output({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
    check_output({tag, "/done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset/req_ready", 32'(req_ready), 32'd1);
    check_output("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset/rsp_rdata", rsp_rdata, 32'd0);
    check_output("reset/rsp_err", 32'(rsp_err), 32'd0);
    check_output("reset/ram_w_en", 32'(ram_w_en), 32'd0);
    check_output("reset/ram_addr", 32'(ram_addr), 32'd0);
    check_output("reset/ram_w_data", ram_w_data, 32'd0);
    check_output("reset/strict_bus", {ram_w_data_s[15:0] | ram_addr_s, 12'd0, ram_w_en_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus("sw_100",  1'b1, 3'b010, 32'h100, 32'h80FF7F01, 32'h0, 1'b0, 4'b1111, 0);
    apply_stimulus("lb_100",  1'b0, 3'b000, 32'h100, 32'h0, 32'h00000001, 1'b0, 4'b0000, 0);
    apply_stimulus("lbu_100", 1'b0, 3'b100, 32'h100, 32'h0, 32'h00000001, 1'b0, 4'b0000, 0);
    apply_stimulus("lh_100",  1'b0, 3'b001, 32'h100, 32'h0, 32'h00007F01, 1'b0, 4'b0000, 0);
    apply_stimulus("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, 32'h00007F01, 1'b0, 4'b0000, 0);
    apply_stimulus("lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 32'h0000007F, 1'b0, 4'b0000, 0);
    apply_stimulus("lh_101",  1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFFFF7F, 1'b0, 4'b0000, 0);
    apply_stimulus("lhu_101", 1'b0, 3'b101, 32'h101, 32'h0, 32'h0000FF7F, 1'b0, 4'b0000, 0);
    apply_stimulus("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0000, 0);
    apply_stimulus("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF7F01, 1'b0, 4'b0000, 0);

    apply_stimulus("sb_102",  1'b1, 3'b000, 32'h102, 32'hFFFFFFAB, 32'h0, 1'b0, 4'b0001, 0);
    apply_stimulus("lw_sb",   1'b0, 3'b010, 32'h100, 32'h0, 32'h80AB7F01, 1'b0, 4'b0000, 0);
    apply_stimulus("sh_103",  1'b1, 3'b001, 32'h103, 32'hCDEF1234, 32'h0, 1'b0, 4'b0011, 0);
    apply_stimulus("lw_sh",   1'b0, 3'b010, 32'h100, 32'h0, 32'h34AB7F01, 1'b0, 4'b0000, 0);

    apply_stimulus("sw_fffc", 1'b1, 3'b010, 32'hFFFC, 32'h11223344, 32'h0, 1'b0, 4'b1111, 0);
    apply_stimulus("lw_fffc", 1'b0, 3'b010, 32'hFFFC, 32'h0, 32'h11223344, 1'b0, 4'b0000, 0);
    apply_stimulus("lbu_ffff", 1'b0, 3'b100, 32'hFFFF, 32'h0, 32'h00000011, 1'b0, 4'b0000, 0);

    apply_stimulus("err_lw_fffe", 1'b0, 3'b010, 32'hFFFE, 32'h0, 32'h0, 1'b1, 4'b0000, 0);
    apply_stimulus("err_sh_ffff", 1'b1, 3'b001, 32'hFFFF, 32'h5555, 32'h0, 1'b1, 4'b0000, 0);
    apply_stimulus("err_sw_hi",   1'b1, 3'b010, 32'h00010000, 32'hCAFEF00D, 32'h0, 1'b1, 4'b0000, 0);
    apply_stimulus("err_f3_011",  1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0000, 0);
    apply_stimulus("err_sb_100",  1'b1, 3'b100, 32'h100, 32'h77, 32'h0, 1'b1, 4'b0000, 0);
    apply_stimulus("lw_after_err", 1'b0, 3'b010, 32'h100, 32'h0, 32'h34AB7F01, 1'b0, 4'b0000, 0);

    apply_stimulus("sw_0",   1'b1, 3'b010, 32'h0, 32'h00000000, 32'h0, 1'b0, 4'b1111, 0);
    apply_stimulus("lh_001", 1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1'b0, 4'b0000, 0);
    check_output("strict_lh_001/err", 32'(rsp_err_s), 32'd1);
    check_output("strict_lh_001/rdata", rsp_rdata_s, 32'd0);
    check_output("strict_lh_001/w_en", 32'(wen_seen_s), 32'd0);
    check_output("strict_lh_001/idle", 32'(req_ready_s & ~rsp_valid_s), 32'd1);

    apply_stimulus("stall_lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'h34AB7F01, 1'b0, 4'b0000, 5);

    // Reset asserted during the ACCESS cycle of a store must block the write.
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("rst_sw/w_en_access", 32'(ram_w_en), 32'hF);
    rst_n = 1'b0;
    #1;
    check_output("rst_sw/w_en", 32'(ram_w_en), 32'd0);
    check_output("rst_sw/rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_sw/req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_output("rst_sw/rsp_valid_after", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 32'h34AB7F01, 1'b0, 4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
